// File: rtl/mmu_arbiter_pkg.sv
// Shared types and widths for the L1I/L1D to l1mmu arbiter.
package mmu_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } state_e;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_e;

   // Payload captured from the winning requester at grant time.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } req_t;

endpackage : mmu_arbiter_pkg

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one l1mmu port between the L1I and L1D caches.
module mmu_arbiter
   import mmu_arbiter_pkg::*;
(
   input  logic              sys_clk,
   input  logic              rst,

   input  logic              immu_read,
   input  logic [ADDR_W-1:0] immu_addr,
   output logic              immu_done,
   output logic [LINE_W-1:0] immu_read_data,

   input  logic              dmmu_read,
   input  logic              dmmu_write,
   input  logic [ADDR_W-1:0] dmmu_addr,
   input  logic [LINE_W-1:0] dmmu_write_data,
   output logic              dmmu_done,
   output logic [LINE_W-1:0] dmmu_read_data,

   output logic              mmu_read,
   output logic              mmu_write,
   output logic [ADDR_W-1:0] mmu_addr,
   output logic [LINE_W-1:0] mmu_write_data,
   input  logic              mmu_done,
   input  logic [LINE_W-1:0] mmu_read_data,

   output logic              arb_busy,
   output logic              arb_owner,
   output logic              arb_err
);

   state_e state_q, state_d;
   owner_e last_q,  last_d;
   req_t   lat_q,   lat_d;
   logic   err_q,   err_d;

   // State, round-robin pointer, latched payload and sticky error.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= OWNER_D;
         lat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         lat_q   <= lat_d;
         err_q   <= err_d;
      end
   end

   // Grant decision in IDLE, completion tracking in the GRANT states.
   always_comb begin
      logic   i_req;
      logic   d_req;
      owner_e win;

      state_d = state_q;
      last_d  = last_q;
      lat_d   = lat_q;
      err_d   = err_q;
      i_req   = immu_read;
      d_req   = dmmu_read | dmmu_write;
      win     = OWNER_I;

      case (state_q)
         ST_IDLE: begin
            // No transaction is outstanding, so a completion here is bogus.
            if (mmu_done) begin
               err_d = 1'b1;
            end
            if (i_req && d_req) begin
               win = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
            end else if (d_req) begin
               win = OWNER_D;
            end else begin
               win = OWNER_I;
            end
            if (i_req || d_req) begin
               last_d = win;
               if (win == OWNER_I) begin
                  state_d     = ST_GRANT_I;
                  lat_d.write = 1'b0;
                  lat_d.addr  = immu_addr;
                  lat_d.wdata = '0;
               end else begin
                  state_d     = ST_GRANT_D;
                  // Simultaneous read and write resolves to the write-back.
                  lat_d.write = dmmu_write;
                  lat_d.addr  = dmmu_addr;
                  lat_d.wdata = dmmu_write ? dmmu_write_data : '0;
                  if (dmmu_read && dmmu_write) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         ST_GRANT_I, ST_GRANT_D: begin
            if (mmu_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // l1mmu request and upstream completion, all derived from registered state.
   always_comb begin
      arb_busy       = (state_q != ST_IDLE) && !rst;
      arb_owner      = arb_busy && (state_q == ST_GRANT_D);
      arb_err        = err_q;
      mmu_read       = arb_busy && !lat_q.write;
      mmu_write      = arb_busy && lat_q.write;
      mmu_addr       = arb_busy ? lat_q.addr  : '0;
      mmu_write_data = arb_busy ? lat_q.wdata : '0;
      immu_done      = arb_busy && (state_q == ST_GRANT_I) && mmu_done;
      dmmu_done      = arb_busy && (state_q == ST_GRANT_D) && mmu_done;
      immu_read_data = immu_done ? mmu_read_data : '0;
      dmmu_read_data = dmmu_done ? mmu_read_data : '0;
   end

endmodule : mmu_arbiter

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter with a done-side scoreboard.
module tb_mmu_arbiter;

   logic         sys_clk;
   logic         rst;
   logic         immu_read;
   logic [31:0]  immu_addr;
   logic         immu_done;
   logic [255:0] immu_read_data;
   logic         dmmu_read;
   logic         dmmu_write;
   logic [31:0]  dmmu_addr;
   logic [255:0] dmmu_write_data;
   logic         dmmu_done;
   logic [255:0] dmmu_read_data;
   logic         mmu_read;
   logic         mmu_write;
   logic [31:0]  mmu_addr;
   logic [255:0] mmu_write_data;
   logic         mmu_done;
   logic [255:0] mmu_read_data;
   logic         arb_busy;
   logic         arb_owner;
   logic         arb_err;

   typedef struct packed {
      logic         side;
      logic [255:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mmu_arbiter dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .immu_read       (immu_read),
      .immu_addr       (immu_addr),
      .immu_done       (immu_done),
      .immu_read_data  (immu_read_data),
      .dmmu_read       (dmmu_read),
      .dmmu_write      (dmmu_write),
      .dmmu_addr       (dmmu_addr),
      .dmmu_write_data (dmmu_write_data),
      .dmmu_done       (dmmu_done),
      .dmmu_read_data  (dmmu_read_data),
      .mmu_read        (mmu_read),
      .mmu_write       (mmu_write),
      .mmu_addr        (mmu_addr),
      .mmu_write_data  (mmu_write_data),
      .mmu_done        (mmu_done),
      .mmu_read_data   (mmu_read_data),
      .arb_busy        (arb_busy),
      .arb_owner       (arb_owner),
      .arb_err         (arb_err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Acts as l1mmu: completes after dly cycles; the requester then drops its request.
   task automatic serve(input int dly, input logic [255:0] data, input logic side);
      exp_t e;
      repeat (dly - 1) tick();
      e.side = side;
      e.data = data;
      exp_q.push_back(e);
      mmu_done      = 1'b1;
      mmu_read_data = data;
      tick();
      mmu_done      = 1'b0;
      mmu_read_data = '0;
      if (side) begin
         dmmu_read  = 1'b0;
         dmmu_write = 1'b0;
      end else begin
         immu_read = 1'b0;
      end
   endtask

   // Monitor: every upstream done pulse must match the next expected completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (immu_done || dmmu_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {254'd0, dmmu_done, immu_done}, '0);
            end else begin
               e = exp_q.pop_front();
               chk("done_both", 256'(immu_done & dmmu_done), '0);
               chk("done_side", 256'(dmmu_done), 256'(e.side));
               chk("done_data", e.side ? dmmu_read_data : immu_read_data, e.data);
            end
         end
         if (!immu_done) chk("i_data_zero", immu_read_data, '0);
         if (!dmmu_done) chk("d_data_zero", dmmu_read_data, '0);
      end
   end

   initial begin
      rst = 1'b1;
      immu_read = 1'b0; immu_addr = '0;
      dmmu_read = 1'b0; dmmu_write = 1'b0; dmmu_addr = '0; dmmu_write_data = '0;
      mmu_done = 1'b0; mmu_read_data = '0;
      tick();
      tick();
      chk("rst_busy",  256'(arb_busy), '0);
      chk("rst_read",  256'(mmu_read), '0);
      chk("rst_write", 256'(mmu_write), '0);
      chk("rst_addr",  256'(mmu_addr), '0);
      chk("rst_err",   256'(arb_err), '0);
      rst = 1'b0;

      // Lone I request
      immu_read = 1'b1; immu_addr = 32'h0000_0100;
      tick();
      chk("t1_read",  256'(mmu_read), 256'(1));
      chk("t1_write", 256'(mmu_write), '0);
      chk("t1_addr",  256'(mmu_addr), 256'(32'h0000_0100));
      chk("t1_busy",  256'(arb_busy), 256'(1));
      chk("t1_owner", 256'(arb_owner), '0);
      serve(3, {32{8'hAA}}, 1'b0);
      chk("t1_idle",  256'(arb_busy), '0);
      chk("t1_rd0",   256'(mmu_read), '0);

      // Tie after reset: I first, then D; I re-requests during IDLE and loses the tie
      do_reset();
      immu_read = 1'b1; immu_addr = 32'h0000_0300;
      dmmu_read = 1'b1; dmmu_addr = 32'h0000_0400;
      tick();
      chk("t2_owner_i", 256'(arb_owner), '0);
      chk("t2_addr_i",  256'(mmu_addr), 256'(32'h0000_0300));
      serve(1, {32{8'h11}}, 1'b0);
      immu_read = 1'b1; immu_addr = 32'h0000_0500;
      chk("t2_gap",     256'(arb_busy), '0);
      tick();
      chk("t2_owner_d", 256'(arb_owner), 256'(1));
      chk("t2_addr_d",  256'(mmu_addr), 256'(32'h0000_0400));
      chk("t2_read_d",  256'(mmu_read), 256'(1));
      serve(1, {32{8'h22}}, 1'b1);
      chk("t2_gap2",    256'(arb_busy), '0);
      tick();
      chk("t2_owner_i2", 256'(arb_owner), '0);
      chk("t2_addr_i2",  256'(mmu_addr), 256'(32'h0000_0500));
      serve(2, {32{8'h33}}, 1'b0);

      // D write-back with address change and I arriving mid-transaction
      dmmu_write = 1'b1; dmmu_addr = 32'h0000_2000;
      dmmu_write_data = {8{32'h1234_5678}};
      tick();
      chk("t3_write", 256'(mmu_write), 256'(1));
      chk("t3_read",  256'(mmu_read), '0);
      chk("t3_wdata", mmu_write_data, {8{32'h1234_5678}});
      chk("t3_owner", 256'(arb_owner), 256'(1));
      dmmu_addr = 32'h9999_0000;
      immu_read = 1'b1; immu_addr = 32'h0000_0600;
      tick();
      chk("t3_addr_hold",  256'(mmu_addr), 256'(32'h0000_2000));
      chk("t3_owner_hold", 256'(arb_owner), 256'(1));
      serve(1, {32{8'h5A}}, 1'b1);
      chk("t3_gap",   256'(arb_busy), '0);
      tick();
      chk("t3_owner_i", 256'(arb_owner), '0);
      chk("t3_addr_i",  256'(mmu_addr), 256'(32'h0000_0600));
      chk("t3_wdata_i", mmu_write_data, '0);
      serve(1, {32{8'hC3}}, 1'b0);
      chk("t3_err", 256'(arb_err), '0);

      // Reset during GRANT_D, colliding with mmu_done; later spurious done
      dmmu_read = 1'b1; dmmu_addr = 32'h0000_0700;
      tick();
      chk("t4_read", 256'(mmu_read), 256'(1));
      rst = 1'b1; mmu_done = 1'b1; mmu_read_data = {32{8'hFF}};
      #1;
      chk("t4_no_done", 256'(dmmu_done), '0);
      tick();
      rst = 1'b0; mmu_done = 1'b0; mmu_read_data = '0; dmmu_read = 1'b0;
      chk("t4_busy",  256'(arb_busy), '0);
      chk("t4_write", 256'(mmu_write), '0);
      chk("t4_rd",    256'(mmu_read), '0);
      chk("t4_err0",  256'(arb_err), '0);
      tick();
      mmu_done = 1'b1;
      tick();
      mmu_done = 1'b0;
      chk("t4_err1", 256'(arb_err), 256'(1));
      do_reset();
      chk("t4_err_clr", 256'(arb_err), '0);

      // Read and write together: write wins, error is sticky
      dmmu_read = 1'b1; dmmu_write = 1'b1; dmmu_addr = 32'h0000_0800;
      dmmu_write_data = {8{32'hCAFE_F00D}};
      tick();
      chk("t5_write", 256'(mmu_write), 256'(1));
      chk("t5_read",  256'(mmu_read), '0);
      chk("t5_wdata", mmu_write_data, {8{32'hCAFE_F00D}});
      chk("t5_err",   256'(arb_err), 256'(1));
      serve(2, {32{8'h77}}, 1'b1);
      repeat (3) tick();
      chk("t5_sticky", 256'(arb_err), 256'(1));
      do_reset();
      chk("t5_clr", 256'(arb_err), '0);

      tick();
      chk("sb_empty", 256'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mmu_arbiter

// File: doc/mmu_arbiter.md
MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 immu_read  in  1  L1I line-read request; level, held until immu_done.
REQ-004 immu_addr  in  32  L1I line address.
REQ-005 immu_done  out  1  one-cycle completion pulse to L1I.
REQ-006 immu_read_data  out  256  line data to L1I; valid only while immu_done=1.
REQ-007 dmmu_read / dmmu_write  in  1 each  L1D line read / write-back request; level, held until dmmu_done.
REQ-008 dmmu_addr  in  32; dmmu_write_data  in  256  L1D address and write-back line.
REQ-009 dmmu_done  out  1; dmmu_read_data  out  256  L1D completion pulse and line data; data valid only while dmmu_done=1.
REQ-010 mmu_read / mmu_write  out  1 each  request to l1mmu; mmu_addr  out  32; mmu_write_data  out  256.
REQ-011 mmu_done  in  1; mmu_read_data  in  256  l1mmu completion pulse and data.
REQ-012 arb_busy  out  1  high in any GRANT state; arb_owner  out  1  0=I, 1=D, valid while arb_busy.
REQ-013 arb_err  out  1  sticky protocol-error flag.

Function
REQ-014 FSM states IDLE, GRANT_I, GRANT_D; state, last_winner, and latched payload registers only.
REQ-015 IDLE, only I requesting -> GRANT_I; only D (read or write) requesting -> GRANT_D; none -> stay IDLE.
REQ-016 IDLE, both requesting -> grant the side not equal to last_winner (round-robin).
REQ-017 On the IDLE->GRANT edge, latch address, op (read/write), and write data of the winner, and set last_winner to the winner.
REQ-018 mmu_read/mmu_write/mmu_addr/mmu_write_data are driven only from the latched registers; request visible to l1mmu exactly 1 cycle after grant decision; all zero in IDLE.
REQ-019 GRANT_I always issues mmu_read=1, mmu_write=0.
REQ-020 dmmu_read and dmmu_write both high at grant -> write op issued, arb_err set.
REQ-021 mmu_done in GRANT_x -> x_done=1 combinationally same cycle, x_read_data=mmu_read_data, other side's done=0; next state IDLE.
REQ-022 Min spacing: one IDLE cycle between consecutive transactions; back-to-back requests from both sides alternate.
REQ-023 Requester deasserting mid-transaction is ignored; transaction runs to mmu_done and the done pulse is still issued.
REQ-024 mmu_done in IDLE is ignored (no upstream done) and sets arb_err.
REQ-025 Read data outputs are 0 whenever the corresponding done is 0.

Reset
REQ-026 rst=1 at an edge -> state IDLE, last_winner=D (I wins the first tie), latched payload 0, arb_err 0.
REQ-027 During/after reset: mmu_read, mmu_write, immu_done, dmmu_done, arb_busy all 0; an in-flight transaction is abandoned with no done pulse.
REQ-028 Reset dominates mmu_done and all requests in the same cycle.

Structure
REQ-029 Shared package holds state enum, owner encoding (OWNER_I=0, OWNER_D=1), LINE_W=256, ADDR_W=32.
REQ-030 Single flat module; no sub-modules; replaces top-level dmmu_pending/serve_ic logic.

Verification
REQ-031 Lone I: immu_read=1, addr 0x0000_0100, mmu_done 3 cycles after mmu_read rises with data 0xAA..AA -> immu_done 1 cycle, immu_read_data=0xAA..AA, dmmu_done=0.
REQ-032 Tie after reset: I and D read requested same cycle -> I granted first (mmu_addr=I addr), D granted after one IDLE cycle; next tie grants D.
REQ-033 D write-back: dmmu_write=1, addr 0x0000_2000, data 0x1234.. -> mmu_write=1, mmu_write_data matches, mmu_read=0; dmmu_done on mmu_done.
REQ-034 Change dmmu_addr during GRANT_D -> mmu_addr keeps latched value; I request arriving mid-D waits, granted after dmmu_done.
REQ-035 rst asserted in GRANT_D before mmu_done -> next cycle IDLE, mmu_write=0, no dmmu_done; later spurious mmu_done -> arb_err=1.
REQ-036 dmmu_read=dmmu_write=1 -> write issued, arb_err=1 sticky until rst.
